// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller, register file and ALU.
// Holds the controller FSM state encoding and the default datapath widths.
package regfile_access_ctrl_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int RA_W_DEF    = 3;
    localparam int RETIRED_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WB    = 3'd5
    } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: reads the operands of one decoded command, hands them to the ALU,
// and writes the result back. Only one command is in flight, so read-after-write needs no bypass.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [RA_W-1:0]      cmd_dr,
    input  logic [RA_W-1:0]      cmd_sr1,
    input  logic [RA_W-1:0]      cmd_sr2,
    input  logic                 cmd_imm_en,
    input  logic [DATA_W-1:0]    cmd_imm,
    input  logic                 cmd_wb_en,
    output logic [RA_W-1:0]      sr1,
    output logic [RA_W-1:0]      sr2,
    input  logic [DATA_W-1:0]    sr1_out,
    input  logic [DATA_W-1:0]    sr2_out,
    output logic                 take_data,
    output logic [RA_W-1:0]      dr,
    output logic [DATA_W-1:0]    dr_in,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [DATA_W-1:0]    op_a,
    output logic [DATA_W-1:0]    op_b,
    input  logic                 res_valid,
    input  logic [DATA_W-1:0]    res_data,
    output logic                 busy,
    output logic [RETIRED_W-1:0] retired
);

    state_t                 r_state;
    state_t                 w_next_state;

    logic [RA_W-1:0]        r_dr_idx;
    logic [RA_W-1:0]        r_sr1;
    logic [RA_W-1:0]        r_sr2;
    logic                   r_imm_en;
    logic [DATA_W-1:0]      r_imm;
    logic                   r_wb_en;
    logic [RA_W-1:0]        r_dr;
    logic [DATA_W-1:0]      r_dr_in;
    logic [DATA_W-1:0]      r_op_a;
    logic [DATA_W-1:0]      r_op_b;
    logic [RETIRED_W-1:0]   r_retired;

    logic                   w_accept;
    logic                   w_res_take;
    logic                   w_retire;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    assign w_res_take = (r_state == ST_WAIT) && res_valid;
    // A command without write-back retires as soon as its result arrives.
    assign w_retire   = (w_res_take && !r_wb_en) || (r_state == ST_WB);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (cmd_valid) w_next_state = ST_RD;
            ST_RD:    w_next_state = ST_CAP;
            ST_CAP:   w_next_state = ST_ISSUE;
            ST_ISSUE: if (op_ready) w_next_state = ST_WAIT;
            ST_WAIT:  if (res_valid) w_next_state = r_wb_en ? ST_WB : ST_IDLE;
            ST_WB:    w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dr_idx  <= '0;
            r_sr1     <= '0;
            r_sr2     <= '0;
            r_imm_en  <= 1'b0;
            r_imm     <= '0;
            r_wb_en   <= 1'b0;
            r_dr      <= '0;
            r_dr_in   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_retired <= '0;
        end else begin
            // Read indices change only on accept, so the RD-cycle sample sees the new command.
            if (w_accept) begin
                r_dr_idx <= cmd_dr;
                r_sr1    <= cmd_sr1;
                r_sr2    <= cmd_sr2;
                r_imm_en <= cmd_imm_en;
                r_imm    <= cmd_imm;
                r_wb_en  <= cmd_wb_en;
            end
            if (r_state == ST_CAP) begin
                r_op_a <= sr1_out;
                r_op_b <= r_imm_en ? r_imm : sr2_out;
            end
            if (w_res_take) begin
                r_dr    <= r_dr_idx;
                r_dr_in <= res_data;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign op_valid  = (r_state == ST_ISSUE);
    assign take_data = (r_state == ST_WB);
    assign sr1       = r_sr1;
    assign sr2       = r_sr2;
    assign dr        = r_dr;
    assign dr_in     = r_dr_in;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign retired   = r_retired;

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator side of the LC-3b register-file port: accepts one decoded register-op command at a time and drives the register file's sr1/sr2 read indices.
- Captures the returned operands (or an immediate) and hands them to the ALU with a valid/ready handshake.
- Writes the ALU result back through the register file's take_data/dr/dr_in write port.
- Sits between the decode stage and the register file/ALU; one command in flight, no bypass needed by construction.

Parameters:
- DATA_W, 16, datapath/register width
- RA_W, 3, register index width (8 registers)

Ports:
- clk  input  1  clock
- rst  input  1  reset
- cmd_valid  input  1  command offered by decode
- cmd_ready  output  1  controller can accept a command
- cmd_dr  input  RA_W  destination register index
- cmd_sr1  input  RA_W  source register 1 index
- cmd_sr2  input  RA_W  source register 2 index
- cmd_imm_en  input  1  operand B is cmd_imm instead of R[sr2]
- cmd_imm  input  DATA_W  sign-extended immediate from decode
- cmd_wb_en  input  1  result is written to R[dr]
- sr1  output  RA_W  register-file read index 1
- sr2  output  RA_W  register-file read index 2
- sr1_out  input  DATA_W  register-file read data 1
- sr2_out  input  DATA_W  register-file read data 2
- take_data  output  1  register-file write enable
- dr  output  RA_W  register-file write index
- dr_in  output  DATA_W  register-file write data
- op_valid  output  1  operands valid to ALU
- op_ready  input  1  ALU accepts operands
- op_a  output  DATA_W  operand A
- op_b  output  DATA_W  operand B
- res_valid  input  1  ALU result valid
- res_data  input  DATA_W  ALU result
- busy  output  1  command in flight (state != IDLE)
- retired  output  16  count of completed commands

Behaviour:
- Reset (rst): synchronous, active-high; clock: clk, rising edge.
- Reset values: state IDLE; cmd_ready=1; sr1, sr2, dr=0; take_data=0; dr_in=0; op_valid=0; op_a, op_b=0; busy=0; retired=0.
- Register-file contract: sr1/sr2 are sampled at a rising edge; data appears on sr1_out/sr2_out in the following cycle. A write committed at the same edge is not visible.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch dr/sr1/sr2/imm_en/imm/wb_en; go to RD.
  - RD: sr1/sr2 driven from latched indices; go to CAP unconditionally.
  - CAP: op_a <= sr1_out; op_b <= imm_en ? imm : sr2_out; go to ISSUE.
  - ISSUE: op_valid=1 and op_a/op_b held stable until op_ready. On op_ready, go to WAIT.
  - WAIT: res_valid is honoured only in this state. On res_valid, latch res_data into dr_in and drive dr from the latched index. If wb_en, go to WB; else go to IDLE and increment retired.
  - WB: take_data=1 for exactly one cycle; go to IDLE and increment retired.
- cmd_ready=1 only in IDLE; busy = !IDLE.
- Latency: command accepted in cycle 0 gives RD in cycle 1, CAP in cycle 2, op_valid in cycle 3. With op_ready in cycle 3 and res_valid in cycle 4, take_data is high in cycle 5.
- Back-to-back: the next command is accepted no earlier than cycle 6, so its RD-edge read follows the write edge. RAW through R[] is always correct without a bypass.
- sr1, sr2, dr, dr_in, op_a, op_b hold their last values outside their driving states. take_data and op_valid are 0 outside WB and ISSUE respectively.
- res_valid outside WAIT is ignored (no latch, no error). op_ready outside ISSUE is ignored.
- sr1 == sr2, or dr equal to a source index: no special handling; behaves normally.
- retired wraps 0xFFFF -> 0x0000.
- Reset mid-operation: the in-flight command is dropped, no write is issued, and all outputs return to reset values on the next edge.

Decomposition:
- Shared package holds the FSM state enum (IDLE, RD, CAP, ISSUE, WAIT, WB) and the DATA_W/RA_W defaults used by the register file and ALU.
- No sub-module required. The retire counter is an inline 16-bit register.

Test Plan:
- Preload R1=0x0005, R2=0x0003. Command sr1=1, sr2=2, dr=3, wb_en=1; ALU model returns a+b in the cycle after op_ready. Expect op_a=0x0005 and op_b=0x0003 in cycle 3, take_data/dr=3/dr_in=0x0008 in cycle 5, R3=0x0008, retired=1.
- Command imm_en=1, imm=0xFFFF, sr1=3, dr=4 immediately after the previous test. Expect op_a=0x0008 (RAW through R3 correct), op_b=0xFFFF, R4=0x0007.
- wb_en=0 command. Expect take_data never asserted and retired increments on the res_valid edge.
- Hold op_ready=0 for 4 cycles, and assert res_valid during ISSUE. Expect op_valid/op_a/op_b stable for all 4 cycles, the early res_valid ignored, and completion only on res_valid in WAIT.
- Assert rst during WAIT. Expect no take_data, outputs at reset values, and the next command processed normally.
- Force retired=0xFFFF via 65535 wb_en=0 commands (or a backdoor load). Expect one more command to wrap retired to 0x0000.
